// File: rtl/digit_entry_sequencer.sv
// Handwritten digit entry sequencer: captures the stroke cell, requests a prediction
// and issues a single write strobe to the Sudoku solver. All outputs are registered.
module digit_entry_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        draw_done,
  input  logic [3:0]  block_x,
  input  logic [3:0]  block_y,
  input  logic [80:0] board_blank,
  output logic        pred_start,
  input  logic        pred_finish,
  input  logic [3:0]  pred_digit,
  output logic        wr_en,
  output logic [3:0]  wr_row,
  output logic [3:0]  wr_col,
  output logic [3:0]  wr_data,
  output logic        busy,
  output logic [2:0]  status,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    WRITE = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    ST_NONE      = 3'd0,
    ST_WRITTEN   = 3'd1,
    ST_BAD_CELL  = 3'd2,
    ST_BAD_DIGIT = 3'd3,
    ST_TIMEOUT   = 3'd4,
    ST_ABORTED   = 3'd5
  } status_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  status_e          status_q, status_d;
  logic             pred_start_q, pred_start_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;
  logic [3:0]       wr_row_q, wr_row_d;
  logic [3:0]       wr_col_q, wr_col_d;
  logic [3:0]       wr_data_q, wr_data_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       row_in_range;
  logic       col_in_range;
  logic [6:0] cell_idx;
  logic       cell_ok;
  logic       digit_ok;
  logic       capture;
  logic       timeout_hit;

  assign row_in_range = (wr_row_q < 4'd9);
  assign col_in_range = (wr_col_q < 4'd9);
  assign capture      = enable && draw_done;
  assign digit_ok     = (pred_digit != 4'd0) && (pred_digit <= 4'd9);
  assign timeout_hit  = (cnt_q == CNT_LAST);

  // Index only formed for in-range coordinates so it never exceeds 80.
  always_comb begin
    cell_idx = '0;
    if (row_in_range && col_in_range) begin
      cell_idx = (7'(wr_row_q) * 7'd9) + 7'(wr_col_q);
    end
  end

  assign cell_ok = row_in_range && col_in_range && board_blank[cell_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      status_q     <= ST_NONE;
      pred_start_q <= 1'b0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      wr_data_q    <= '0;
      drop_cnt_q   <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      pred_start_q <= pred_start_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      wr_data_q    <= wr_data_d;
      drop_cnt_q   <= drop_cnt_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (capture) state_d = CHECK;
      end
      CHECK: begin
        if (!enable || !cell_ok) state_d = IDLE;
        else                     state_d = REQ;
      end
      REQ: begin
        if (!enable) state_d = IDLE;
        else         state_d = WAIT;
      end
      WAIT: begin
        if (!enable)          state_d = IDLE;
        else if (pred_finish) state_d = digit_ok ? WRITE : IDLE;
        else if (timeout_hit) state_d = IDLE;
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered strobes are set on the transition into REQ/WRITE so they are
  // high exactly while the FSM occupies those states.
  always_comb begin
    status_d     = status_q;
    pred_start_d = 1'b0;
    wr_en_d      = 1'b0;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    wr_data_d    = wr_data_q;
    cnt_d        = cnt_q;
    drop_cnt_d   = drop_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (capture) begin
          wr_row_d = block_y;
          wr_col_d = block_x;
        end
      end
      CHECK: begin
        if (!enable)       status_d = ST_ABORTED;
        else if (!cell_ok) status_d = ST_BAD_CELL;
        else               pred_start_d = 1'b1;
      end
      REQ: begin
        cnt_d = '0;
        if (!enable) status_d = ST_ABORTED;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!enable) begin
          status_d = ST_ABORTED;
        end else if (pred_finish) begin
          if (digit_ok) begin
            wr_data_d = pred_digit;
            wr_en_d   = 1'b1;
          end else begin
            status_d = ST_BAD_DIGIT;
          end
        end else if (timeout_hit) begin
          status_d = ST_TIMEOUT;
        end
      end
      WRITE: begin
        // The strobe is already on the wire, so the entry counts as written.
        status_d = ST_WRITTEN;
      end
      default: begin
        status_d = status_q;
      end
    endcase

    if (draw_done && (state_q != IDLE) && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  assign busy_d = (state_d != IDLE);

  assign pred_start = pred_start_q;
  assign wr_en      = wr_en_q;
  assign wr_row     = wr_row_q;
  assign wr_col     = wr_col_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign status     = status_q;
  assign drop_cnt   = drop_cnt_q;

  a_wr_en_single: assert property (@(posedge clk) disable iff (!rst_n) wr_en_q |=> !wr_en_q);
  a_pred_start_single: assert property (@(posedge clk) disable iff (!rst_n) pred_start_q |=> !pred_start_q);

endmodule

// File: tb/tb_digit_entry_sequencer.sv
// Bench for digit_entry_sequencer: directed entry table, multi-cycle corner sequences,
// then randomized traffic against an entry-level reference model.
module tb_digit_entry_sequencer;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        draw_done = 1'b0;
  logic [3:0]  block_x = '0;
  logic [3:0]  block_y = '0;
  logic [80:0] board_blank = '1;
  logic        pred_finish = 1'b0;
  logic [3:0]  pred_digit = '0;
  logic        pred_start, wr_en, busy;
  logic [3:0]  wr_row, wr_col, wr_data;
  logic [2:0]  status;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;
  int wr_seen = 0;
  int ps_seen = 0;
  bit model_on = 1'b0;

  digit_entry_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .draw_done(draw_done),
    .block_x(block_x), .block_y(block_y), .board_blank(board_blank),
    .pred_start(pred_start), .pred_finish(pred_finish), .pred_digit(pred_digit),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .busy(busy), .status(status), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) wr_seen++;
    if (pred_start) ps_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks an entry by its age in cycles since capture.
  bit m_active, m_writing;
  int m_age;
  int e_row, e_col, e_data, e_status, e_drop;
  bit e_ps, e_wr;

  function automatic void model_reset();
    m_active = 0; m_writing = 0; m_age = 0;
    e_row = 0; e_col = 0; e_data = 0; e_status = 0; e_drop = 0;
    e_ps = 0; e_wr = 0;
  endfunction

  function automatic void model_step();
    bit was;
    was  = m_active;
    e_ps = 0;
    e_wr = 0;
    if (draw_done && was) e_drop = (e_drop < 255) ? e_drop + 1 : 255;
    if (!was) begin
      if (enable && draw_done) begin
        m_active = 1; m_age = 1;
        e_row = int'(block_y); e_col = int'(block_x);
      end
    end else if (m_writing) begin
      e_status = 1; m_active = 0; m_writing = 0;
    end else if (!enable) begin
      e_status = 5; m_active = 0;
    end else if (m_age == 1) begin
      if (e_row > 8 || e_col > 8) begin
        e_status = 2; m_active = 0;
      end else if (board_blank[e_row*9 + e_col] == 1'b0) begin
        e_status = 2; m_active = 0;
      end else begin
        m_age = 2; e_ps = 1;
      end
    end else if (m_age == 2) begin
      m_age = 3;
    end else if (pred_finish) begin
      if (pred_digit >= 4'd1 && pred_digit <= 4'd9) begin
        e_data = int'(pred_digit); e_wr = 1; m_writing = 1;
      end else begin
        e_status = 3; m_active = 0;
      end
    end else if (m_age - 3 == T - 1) begin
      e_status = 4; m_active = 0;
    end else begin
      m_age++;
    end
  endfunction

  task automatic model_check();
    chk("rnd_pred_start", int'(pred_start), int'(e_ps));
    chk("rnd_wr_en", int'(wr_en), int'(e_wr));
    chk("rnd_wr_row", int'(wr_row), e_row);
    chk("rnd_wr_col", int'(wr_col), e_col);
    chk("rnd_wr_data", int'(wr_data), e_data);
    chk("rnd_busy", int'(busy), int'(m_active));
    chk("rnd_status", int'(status), e_status);
    chk("rnd_drop_cnt", int'(drop_cnt), e_drop);
  endtask

  task automatic tick();
    @(posedge clk);
    if (model_on) model_step();
    #1;
    if (model_on) model_check();
  endtask

  typedef struct {
    int x; int y; bit blank; int digit; int delay; int exp_status;
  } vec_t;

  task automatic run_entry(input vec_t v);
    logic [80:0] bb;
    int w0, p0;
    for (int i = 0; i < 81; i++) bb[i] = 1'($urandom_range(0, 1));
    if (v.x < 9 && v.y < 9) bb[v.y*9 + v.x] = v.blank;
    board_blank = bb;
    w0 = wr_seen; p0 = ps_seen;
    block_x = 4'(v.x); block_y = 4'(v.y); draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    chk("busy_after_capture", int'(busy), 1);
    tick();
    if (v.exp_status == 2) begin
      chk("badcell_busy", int'(busy), 0);
      chk("badcell_status", int'(status), 2);
      chk("badcell_no_pred_start", int'(pred_start), 0);
      tick();
      chk("badcell_no_write", wr_seen - w0, 0);
      chk("badcell_no_req", ps_seen - p0, 0);
    end else begin
      chk("pred_start_latency", int'(pred_start), 1);
      tick();
      chk("pred_start_one_cycle", int'(pred_start), 0);
      repeat (v.delay) tick();
      pred_finish = 1'b1; pred_digit = 4'(v.digit);
      tick();
      pred_finish = 1'b0;
      if (v.exp_status == 1) begin
        chk("write_wr_en", int'(wr_en), 1);
        chk("write_row", int'(wr_row), v.y);
        chk("write_col", int'(wr_col), v.x);
        chk("write_data", int'(wr_data), v.digit);
        tick();
        chk("write_wr_en_drop", int'(wr_en), 0);
        chk("write_status", int'(status), 1);
        chk("write_busy", int'(busy), 0);
        chk("write_count", wr_seen - w0, 1);
      end else begin
        chk("baddigit_wr_en", int'(wr_en), 0);
        chk("baddigit_status", int'(status), 3);
        chk("baddigit_busy", int'(busy), 0);
        tick();
        chk("baddigit_no_write", wr_seen - w0, 0);
      end
    end
  endtask

  task automatic reach_wait(input int x, input int y);
    board_blank = '1;
    block_x = 4'(x); block_y = 4'(y); draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    tick();
    tick();
  endtask

  vec_t vecs[8];
  int w0;

  initial begin
    vecs[0] = '{x: 3, y: 5, blank: 1'b1, digit: 7,  delay: 10, exp_status: 1};
    vecs[1] = '{x: 2, y: 0, blank: 1'b0, digit: 0,  delay: 0,  exp_status: 2};
    vecs[2] = '{x: 4, y: 4, blank: 1'b1, digit: 0,  delay: 2,  exp_status: 3};
    vecs[3] = '{x: 8, y: 8, blank: 1'b1, digit: 9,  delay: 0,  exp_status: 1};
    vecs[4] = '{x: 9, y: 0, blank: 1'b1, digit: 5,  delay: 0,  exp_status: 2};
    vecs[5] = '{x: 6, y: 1, blank: 1'b1, digit: 12, delay: 5,  exp_status: 3};
    vecs[6] = '{x: 0, y: 15, blank: 1'b1, digit: 5, delay: 0,  exp_status: 2};
    vecs[7] = '{x: 0, y: 0, blank: 1'b1, digit: 1,  delay: 3,  exp_status: 1};

    #12;
    chk("reset_busy", int'(busy), 0);
    chk("reset_pred_start", int'(pred_start), 0);
    chk("reset_wr_en", int'(wr_en), 0);
    chk("reset_wr_row", int'(wr_row), 0);
    chk("reset_status", int'(status), 0);
    chk("reset_drop_cnt", int'(drop_cnt), 0);
    rst_n = 1'b1;
    enable = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_entry(vecs[i]);

    enable = 1'b0; draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    chk("disabled_idle_busy", int'(busy), 0);
    chk("disabled_idle_drop", int'(drop_cnt), 0);
    enable = 1'b1;
    tick();

    w0 = wr_seen;
    reach_wait(1, 1);
    repeat (15) tick();
    chk("timeout_still_busy", int'(busy), 1);
    tick();
    chk("timeout_status", int'(status), 4);
    chk("timeout_busy", int'(busy), 0);
    pred_finish = 1'b1; pred_digit = 4'd5;
    tick();
    pred_finish = 1'b0;
    tick();
    chk("late_finish_no_write", wr_seen - w0, 0);
    chk("late_finish_busy", int'(busy), 0);

    reach_wait(2, 7);
    repeat (15) tick();
    pred_finish = 1'b1; pred_digit = 4'd5;
    tick();
    pred_finish = 1'b0;
    chk("finish_beats_timeout", int'(wr_en), 1);
    tick();
    chk("finish_beats_timeout_status", int'(status), 1);

    reach_wait(4, 3);
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    chk("drop_one", int'(drop_cnt), 1);
    chk("drop_still_busy", int'(busy), 1);
    pred_finish = 1'b1; pred_digit = 4'd6;
    tick();
    pred_finish = 1'b0;
    chk("drop_entry_write", int'(wr_en), 1);
    chk("drop_entry_data", int'(wr_data), 6);
    tick();

    board_blank = '1; block_x = 4'd0; block_y = 4'd0; draw_done = 1'b1;
    repeat (400) tick();
    draw_done = 1'b0;
    chk("drop_saturate", int'(drop_cnt), 255);
    repeat (20) tick();

    w0 = wr_seen;
    reach_wait(3, 2);
    tick();
    tick();
    enable = 1'b0;
    tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_status", int'(status), 5);
    chk("abort_wr_en", int'(wr_en), 0);
    enable = 1'b1;
    pred_finish = 1'b1; pred_digit = 4'd4;
    tick();
    pred_finish = 1'b0;
    tick();
    chk("abort_no_write", wr_seen - w0, 0);

    reach_wait(5, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_row", int'(wr_row), 0);
    chk("async_rst_col", int'(wr_col), 0);
    chk("async_rst_status", int'(status), 0);
    chk("async_rst_drop", int'(drop_cnt), 0);
    chk("async_rst_wr_en", int'(wr_en), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("after_rst_busy", int'(busy), 0);

    model_reset();
    model_on = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      enable      = ($urandom_range(0, 99) < 93);
      draw_done   = ($urandom_range(0, 99) < 12);
      block_x     = 4'($urandom_range(0, 10));
      block_y     = 4'($urandom_range(0, 10));
      for (int i = 0; i < 81; i++) board_blank[i] = ($urandom_range(0, 4) != 0);
      pred_finish = ($urandom_range(0, 99) < 12);
      pred_digit  = 4'($urandom_range(0, 11));
      tick();
    end
    model_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
